branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised conditional-branch direction predictor for the pipelined core.
- Supplies the ID-stage taken/not-taken guess that selects the next fetch address. EX then resolves the branch and compares it against the guess.
- Successor to the core's fixed predict-not-taken behaviour. Adds configurable table depth, history length and indexing mode (bimodal or gshare), plus a self-initialising table, a soft clear and saturating statistics counters.

Parameters:
IDX_W, 8, table index width; table holds 2^IDX_W 2-bit saturating counters
GHR_W, 8, global history length in bits; must satisfy 1 <= GHR_W <= IDX_W
MODE, 1, 0 = bimodal (index = pc[IDX_W-1:0]), 1 = gshare (index = pc[IDX_W-1:0] XOR zero-extended ghr)
INIT_CNT, 2'b01, value written to every counter during initialisation (weakly not-taken)
STAT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
clr  in  1  soft clear: restarts table initialisation and zeroes ghr
rdy  out  1  high when the table is initialised and predictions are valid
q_vld  in  1  ID stage holds a conditional branch and is advancing this cycle
q_pc  in  32  word address of the queried branch
pred_taken  out  1  prediction for q_pc (combinational, same cycle)
pred_ghr  out  GHR_W  history used for this prediction; the pipeline carries it to EX
upd_vld  in  1  EX resolves a conditional branch this cycle
upd_pc  in  32  word address of the resolved branch
upd_ghr  in  GHR_W  history snapshot that travelled with the branch
upd_taken  in  1  actual outcome
upd_mispred  in  1  actual outcome differs from the prediction
stat_lookups  out  STAT_W  accepted queries
stat_mispreds  out  STAT_W  mispredictions reported

Behaviour:
- Async reset (rstn low):
  - ghr = 0, rdy = 0, statistics counters = 0.
  - FSM enters ST_INIT with sweep index = 0.
  - Table contents are not reset directly.
- ST_INIT:
  - Each cycle writes INIT_CNT at the sweep index and increments the index.
  - After writing index 2^IDX_W-1, moves to ST_RUN and sets rdy = 1 on the next edge.
  - Init latency is exactly 2^IDX_W cycles after reset release.
  - While in ST_INIT: pred_taken = 0; q_vld and upd_vld are ignored (no ghr shift, no counter change, no stats change).
- ST_RUN:
  - pred_taken = table[qidx][1], where qidx is formed from q_pc and the current ghr according to MODE.
  - pred_ghr = current ghr.
  - Both outputs are valid in the same cycle as q_pc.
- Speculative history: on q_vld in ST_RUN, ghr <= {ghr[GHR_W-2:0], pred_taken}.
- Update on upd_vld in ST_RUN:
  - uidx is formed from upd_pc and upd_ghr according to MODE.
  - Counter saturates: taken increments to at most 3, not-taken decrements to at least 0.
  - Write takes effect at the next edge.
- Mispredict (upd_vld & upd_mispred):
  - ghr <= {upd_ghr[GHR_W-2:0], upd_taken}.
  - This overrides any same-cycle q_vld shift, because the querying instruction is being flushed.
  - stat_mispreds increments.
- Same-index collision (query and update to the same index in one cycle): the query reads the old value (read-before-write).
- Statistics:
  - stat_lookups increments on accepted q_vld.
  - Both counters saturate at all-ones (no wrap).
- Soft clear:
  - clr high in any state sets ST_INIT with index = 0, ghr = 0, rdy = 0.
  - Statistics counters are not cleared.
  - If clr is held, initialisation restarts every cycle.
- When MODE = 0, ghr is still maintained but does not affect indexing.
- upd_mispred without upd_vld is ignored.
- Reset asserted mid-sweep or mid-run aborts immediately (asynchronous) and the sweep restarts at index 0.

Test Plan:
- Init timing: IDX_W=4; release rstn -> rdy rises exactly 16 cycles later; q_vld during init -> pred_taken=0 and stat_lookups stays 0.
- Saturation: MODE=0; upd_pc=5, upd_taken=1 sent three times -> pred_taken(q_pc=5)=1, counter=3. Four further not-taken updates -> counter=0, pred_taken=0, with no wrap at either end.
- gshare indexing: MODE=1, IDX_W=4, GHR_W=4. Query q_pc=0x3 with ghr=0b0101 hits entry 6, and ghr becomes 0b1010 after the edge. Update with upd_pc=0x3, upd_ghr=0b0101 modifies entry 6 only.
- Mispredict recovery: two q_vld queries shift ghr, then upd_mispred with upd_ghr=0b0011, upd_taken=1 and a simultaneous q_vld -> ghr=0b0111, and stat_mispreds increments by 1.
- Collision: query and not-taken update to the same index with counter=2 -> pred_taken=1 in that cycle, pred_taken=0 the next cycle.
- Soft clear: clr pulse in ST_RUN after training -> rdy=0 for 2^IDX_W cycles, all counters read back as INIT_CNT, ghr=0, statistics preserved.

Source files
------------

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//
// Bundles the signals between the pipeline and the branch direction predictor.
//
//   clr           pipeline -> predictor  soft clear (restart table init, zero ghr)
//   rdy           predictor -> pipeline  table initialised, predictions valid
//   q_vld, q_pc   pipeline -> predictor  ID-stage query (advancing conditional branch)
//   pred_taken    predictor -> pipeline  direction guess for q_pc (same cycle)
//   pred_ghr      predictor -> pipeline  history used for the guess, travels to EX
//   upd_vld       pipeline -> predictor  EX resolves a conditional branch
//   upd_pc        pipeline -> predictor  word address of the resolved branch
//   upd_ghr       pipeline -> predictor  history snapshot carried with the branch
//   upd_taken     pipeline -> predictor  actual outcome
//   upd_mispred   pipeline -> predictor  outcome differed from the guess
//   stat_lookups  predictor -> pipeline  accepted queries (saturating)
//   stat_mispreds predictor -> pipeline  reported mispredictions (saturating)
//
// master = pipeline side, slave = predictor side.
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int GHR_W  = 8,
    parameter int STAT_W = 32
);
    logic              clr;
    logic              rdy;
    logic              q_vld;
    logic [31:0]       q_pc;
    logic              pred_taken;
    logic [GHR_W-1:0]  pred_ghr;
    logic              upd_vld;
    logic [31:0]       upd_pc;
    logic [GHR_W-1:0]  upd_ghr;
    logic              upd_taken;
    logic              upd_mispred;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_mispreds;

    modport master (
        output clr,
        output q_vld,
        output q_pc,
        output upd_vld,
        output upd_pc,
        output upd_ghr,
        output upd_taken,
        output upd_mispred,
        input  rdy,
        input  pred_taken,
        input  pred_ghr,
        input  stat_lookups,
        input  stat_mispreds
    );

    modport slave (
        input  clr,
        input  q_vld,
        input  q_pc,
        input  upd_vld,
        input  upd_pc,
        input  upd_ghr,
        input  upd_taken,
        input  upd_mispred,
        output rdy,
        output pred_taken,
        output pred_ghr,
        output stat_lookups,
        output stat_mispreds
    );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Conditional-branch direction predictor: a table of 2^IDX_W two-bit saturating
// counters indexed either by the branch PC (bimodal, MODE=0) or by the PC XOR
// the global history register (gshare, MODE=1).
//
// After reset or a soft clear the table sweeps itself to INIT_CNT, one entry
// per cycle; predictions are forced not-taken and queries/updates are ignored
// until rdy rises.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bp    predictor side of branch_predictor_if (query, update, status, stats)
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int         IDX_W    = 8,
    parameter int         GHR_W    = 8,
    parameter int         MODE     = 1,
    parameter logic [1:0] INIT_CNT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    branch_predictor_if.slave    bp
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  sweep_reg;
    logic [GHR_W-1:0]  ghr_reg;
    logic              rdy_reg;

    // Counter table. Read combinationally so the guess is available in the
    // same cycle as the query; contents are never reset, only swept.
    logic [1:0]        table_mem [DEPTH];

    logic              is_run;
    logic [IDX_W-1:0]  q_ghr_ext;
    logic [IDX_W-1:0]  u_ghr_ext;
    logic [IDX_W-1:0]  qidx;
    logic [IDX_W-1:0]  uidx;
    logic              pred_bit;
    logic              pred_taken;
    logic [1:0]        u_cnt;
    logic [1:0]        u_cnt_next;
    logic              q_acc;
    logic              u_acc;
    logic              mp_acc;
    logic [1:0]        stat_inc;

    assign is_run = (state_reg == ST_RUN);

    // Zero-extend the history to the index width (GHR_W may equal IDX_W,
    // so a replication-based extension could be zero-width).
    always_comb begin
        q_ghr_ext = '0;
        u_ghr_ext = '0;
        q_ghr_ext[GHR_W-1:0] = ghr_reg;
        u_ghr_ext[GHR_W-1:0] = bp.upd_ghr;
    end

    generate
        if (MODE == 1) begin : g_gshare
            assign qidx = bp.q_pc[IDX_W-1:0]   ^ q_ghr_ext;
            assign uidx = bp.upd_pc[IDX_W-1:0] ^ u_ghr_ext;
        end else begin : g_bimodal
            assign qidx = bp.q_pc[IDX_W-1:0];
            assign uidx = bp.upd_pc[IDX_W-1:0];
        end
    endgenerate

    // Upper PC bits never take part in indexing; in bimodal mode the history
    // extensions are unused as well.
    logic unused_bits;
    assign unused_bits = &{1'b0, bp.q_pc[31:IDX_W], bp.upd_pc[31:IDX_W],
                           q_ghr_ext, u_ghr_ext};

    // Query path: the MSB of the counter is the direction guess. Forced
    // not-taken while the table is still being swept.
    assign pred_bit   = table_mem[qidx][1];
    assign pred_taken = is_run & pred_bit;

    assign q_acc  = is_run & bp.q_vld;
    assign u_acc  = is_run & bp.upd_vld;
    assign mp_acc = u_acc & bp.upd_mispred;

    // Saturating counter step for the resolved branch.
    assign u_cnt = table_mem[uidx];

    always_comb begin
        u_cnt_next = u_cnt;
        if (bp.upd_taken) begin
            if (u_cnt != 2'b11) begin
                u_cnt_next = u_cnt + 2'd1;
            end
        end else begin
            if (u_cnt != 2'b00) begin
                u_cnt_next = u_cnt - 2'd1;
            end
        end
    end

    // Single write port: sweep writes during init, training writes in run.
    // A query in the same cycle as an update to the same entry sees the old
    // value because the write lands on the edge.
    always_ff @(posedge clk) begin
        if (!is_run) begin
            table_mem[sweep_reg] <= INIT_CNT;
        end else if (u_acc) begin
            table_mem[uidx] <= u_cnt_next;
        end
    end

    // Control FSM with history register and registered ready flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_INIT;
            sweep_reg <= '0;
            ghr_reg   <= '0;
            rdy_reg   <= 1'b0;
        end else if (bp.clr) begin
            state_reg <= ST_INIT;
            sweep_reg <= '0;
            ghr_reg   <= '0;
            rdy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    sweep_reg <= sweep_reg + 1'b1;
                    if (sweep_reg == '1) begin
                        state_reg <= ST_RUN;
                        rdy_reg   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A mispredict flushes the querying instruction, so the
                    // repaired history wins over the speculative shift.
                    // The size cast keeps the low GHR_W bits of the shift.
                    if (mp_acc) begin
                        ghr_reg <= GHR_W'({bp.upd_ghr, bp.upd_taken});
                    end else if (bp.q_vld) begin
                        ghr_reg <= GHR_W'({ghr_reg, pred_taken});
                    end
                end
                default: begin
                    state_reg <= ST_INIT;
                    sweep_reg <= '0;
                end
            endcase
        end
    end

    // Statistics: [0] accepted lookups, [1] mispredictions. Both saturate at
    // all-ones and survive a soft clear.
    assign stat_inc = {mp_acc, q_acc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [STAT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign bp.rdy           = rdy_reg;
    assign bp.pred_taken    = pred_taken;
    assign bp.pred_ghr      = ghr_reg;
    assign bp.stat_lookups  = g_stat[0].cnt_reg;
    assign bp.stat_mispreds = g_stat[1].cnt_reg;

endmodule
